// File: rtl/scan_tgt_pkg.sv
// -----------------------------------------------------------------------------
// scan_tgt_pkg
//   Shared definitions for the scan target responder: address field layout,
//   error bit positions, latency counter width, FSM state encoding and the
//   captured-request record.
// -----------------------------------------------------------------------------
package scan_tgt_pkg;

   localparam int SPACE_BIT = 14;            // 0: register space, 1: memory
   localparam int ADDR_W    = 15;
   localparam int IDX_W     = 14;            // index field below SPACE_BIT
   localparam int DATA_W    = 32;
   localparam int LAT_W     = 4;             // latency parameters are 0..15

   localparam int ERR_W        = 3;
   localparam int ERR_UNMAPPED = 0;
   localparam int ERR_OVERRUN  = 1;
   localparam int ERR_BOTH     = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic             wr;
      logic             is_mem;
      logic             mapped;
      logic [IDX_W-1:0] idx;
   } req_t;

   // One extra bit so a limit of 2**IDX_W still compares correctly.
   function automatic logic idx_mapped(input logic [IDX_W-1:0] idx,
                                       input int unsigned      limit);
      return {1'b0, idx} < (IDX_W+1)'(limit);
   endfunction

endpackage

// File: rtl/scan_tgt_mem.sv
// -----------------------------------------------------------------------------
// scan_tgt_mem
//   Single-port synchronous RAM, DEPTH x 32, write-first. The read/write port
//   output register only updates when en=1, so it holds the last access result.
//   No reset on contents or output.
// Ports:
//   clk    in   clock
//   en     in   access enable
//   we     in   write enable (with en)
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data (write data on a write)
// -----------------------------------------------------------------------------
module scan_tgt_mem #(
   parameter int DEPTH = 256,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[addr] <= wdata;
            rdata_q     <= wdata;
         end else begin
            rdata_q     <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/scan_tgt_rsp.sv
// -----------------------------------------------------------------------------
// scan_tgt_rsp
//   Responder end of the scan request interface. Single-cycle wen/ren pulses
//   are served from a register bank (register 0 = read-only ID) or from a word
//   memory, and completed with a one-cycle scan_ready pulse after a
//   programmable latency.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   scan_wen     write request pulse
//   scan_ren     read request pulse
//   scan_addr    [14]=space select, [13:0]=index; valid in request cycle only
//   scan_wdata   write data; valid in request cycle only
//   scan_rdata   response data; valid with scan_ready, held afterwards
//   scan_ready   one-cycle completion pulse
//   busy         high from the cycle after acceptance through scan_ready
//   reg_q        flattened register bank, slot i = [32i+31:32i]
//   err          sticky errors: [0] unmapped, [1] overrun, [2] wen&ren
//   err_clr      clears err (a same-cycle set event wins)
// -----------------------------------------------------------------------------
module scan_tgt_rsp
   import scan_tgt_pkg::*;
#(
   parameter int          NREGS     = 16,
   parameter int          MEM_DEPTH = 256,
   parameter int          RD_LAT    = 1,
   parameter int          WR_LAT    = 0,
   parameter logic [31:0] ID_VAL    = 32'h5CA1_0001
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    scan_wen,
   input  logic                    scan_ren,
   input  logic [ADDR_W-1:0]       scan_addr,
   input  logic [DATA_W-1:0]       scan_wdata,
   output logic [DATA_W-1:0]       scan_rdata,
   output logic                    scan_ready,
   output logic                    busy,
   output logic [32*NREGS-1:0]     reg_q,
   output logic [ERR_W-1:0]        err,
   input  logic                    err_clr
);

   localparam int REG_AW = $clog2(NREGS);
   localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [LAT_W-1:0] RD_LAT_C = LAT_W'(RD_LAT);
   localparam logic [LAT_W-1:0] WR_LAT_C = LAT_W'(WR_LAT);

   state_e                       state_q, state_d;
   logic [LAT_W-1:0]             cnt_q, cnt_d;
   req_t                         req_q, req_d;
   logic [NREGS-1:1][DATA_W-1:0] regs_q, regs_d;
   logic [DATA_W-1:0]            rdata_q, rdata_d;
   logic                         rsp_mem_q, rsp_mem_d;
   logic                         ready_q, ready_d;
   logic                         busy_q, busy_d;
   logic [ERR_W-1:0]             err_q, err_d;

   logic [NREGS-1:0][DATA_W-1:0] reg_view;
   req_t                         req_in, cur;
   logic                         req_vld, in_mapped, enter_resp, from_idle;
   logic [LAT_W-1:0]             lat_in;
   logic                         mem_en, mem_we;
   logic [MEM_AW-1:0]            mem_addr;
   logic [DATA_W-1:0]            mem_rdata;

   // Slot 0 is the constant ID; only slots 1..NREGS-1 are flops.
   assign reg_view = {regs_q, ID_VAL};
   assign reg_q    = reg_view;

   assign req_vld   = scan_wen | scan_ren;
   assign in_mapped = scan_addr[SPACE_BIT] ? idx_mapped(scan_addr[IDX_W-1:0], MEM_DEPTH)
                                           : idx_mapped(scan_addr[IDX_W-1:0], NREGS);
   assign lat_in    = scan_wen ? WR_LAT_C : RD_LAT_C;

   always_comb begin
      req_in.wr     = scan_wen;        // wen&ren is treated as a write
      req_in.is_mem = scan_addr[SPACE_BIT];
      req_in.mapped = in_mapped;
      req_in.idx    = scan_addr[IDX_W-1:0];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      regs_d     = regs_q;
      rdata_d    = rdata_q;
      rsp_mem_d  = rsp_mem_q;
      busy_d     = busy_q;
      ready_d    = 1'b0;
      err_d      = err_clr ? '0 : err_q;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = req_q.idx[MEM_AW-1:0];
      enter_resp = 1'b0;
      from_idle  = 1'b0;
      cur        = req_q;

      case (state_q)
         ST_IDLE: begin
            if (req_vld) begin
               req_d     = req_in;
               busy_d    = 1'b1;
               // Freeze the visible response data so it stays put while busy,
               // even if the RAM output port is reused for this access.
               rdata_d   = scan_rdata;
               rsp_mem_d = 1'b0;
               from_idle = 1'b1;
               cur       = req_in;
               if (lat_in == '0) begin
                  state_d    = ST_RESP;
                  cnt_d      = '0;
                  enter_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = lat_in - LAT_W'(1);
               end
               if (!req_in.mapped)       err_d[ERR_UNMAPPED] = 1'b1;
               if (scan_wen && scan_ren) err_d[ERR_BOTH]     = 1'b1;
               // Writes commit at the acceptance edge.
               if (scan_wen && req_in.mapped) begin
                  if (req_in.is_mem) begin
                     mem_en   = 1'b1;
                     mem_we   = 1'b1;
                     mem_addr = req_in.idx[MEM_AW-1:0];
                  end else if (req_in.idx != '0) begin
                     regs_d[req_in.idx[REG_AW-1:0]] = scan_wdata;
                  end
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - LAT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase

      // Anything arriving while not idle is dropped and flagged.
      if (req_vld && state_q != ST_IDLE) err_d[ERR_OVERRUN] = 1'b1;

      // Last cycle before RESP: sample the response value. Memory data comes
      // out of the RAM register during RESP and is held there afterwards.
      if (enter_resp) begin
         ready_d = 1'b1;
         if (cur.mapped && cur.is_mem) begin
            rsp_mem_d = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = cur.idx[MEM_AW-1:0];
         end else begin
            rsp_mem_d = 1'b0;
            if (!cur.mapped)
               rdata_d = '0;
            else if (from_idle && cur.wr && cur.idx != '0)
               rdata_d = scan_wdata;   // register not yet updated this cycle
            else
               rdata_d = reg_view[cur.idx[REG_AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         req_q     <= '0;
         regs_q    <= '0;
         rdata_q   <= '0;
         rsp_mem_q <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         regs_q    <= regs_d;
         rdata_q   <= rdata_d;
         rsp_mem_q <= rsp_mem_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   scan_tgt_mem #(
      .DEPTH (MEM_DEPTH),
      .AW    (MEM_AW)
   ) u_mem (
      .clk   (clk),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (scan_wdata),
      .rdata (mem_rdata)
   );

   assign scan_rdata = rsp_mem_q ? mem_rdata : rdata_q;
   assign scan_ready = ready_q;
   assign busy       = busy_q;
   assign err        = err_q;

endmodule
